chip8_keypad_ctrl: RTL and testbench

//  Conditions the 16 raw hex-keypad levels (PS/2 or joystick mapper) for the CHIP-8 core.
//  Per key: 2-flop sync, tick-sampled debounce, rising-edge pulse.

---
 rtl/chip8_keypad_ctrl_pkg.sv | 27 ++
 rtl/chip8_keypad_ctrl_if.sv | 15 +
 rtl/chip8_keypad_ctrl_debounce.sv | 62 ++++++
 rtl/chip8_keypad_ctrl.sv | 120 ++++++++++++
 tb/tb_chip8_keypad_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/chip8_keypad_ctrl_pkg.sv
// rtl/chip8_keypad_ctrl_pkg.sv - shared constants, wait FSM encoding and key priority helper
// Purpose: key count, key index width, wait FSM state type and the lowest-index
//          encoder used when several keys report a press in the same cycle.
// Ports:   none (package).
package chip8_keypad_ctrl_pkg;

  localparam int NUM_KEYS  = 16;
  localparam int KEY_IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_WAIT_RELEASE = 2'd2,
    ST_HOLD         = 2'd3
  } wait_state_e;

  // Scan from the top down so the lowest set bit is the last one written.
  function automatic logic [KEY_IDX_W-1:0] lowest_set_idx(input logic [NUM_KEYS-1:0] vec);
    logic [KEY_IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (vec[i]) idx = KEY_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/chip8_keypad_ctrl_if.sv
// rtl/chip8_keypad_ctrl_if.sv - FX0A wait-for-key handshake between CPU and keypad controller
// Purpose: groups the wait request level, the one-cycle ack and the returned key index.
// Ports:   wait_req (CPU -> ctrl), wait_ack (ctrl -> CPU), wait_key[3:0] (ctrl -> CPU).
//          master = CPU side, slave = keypad controller side.
interface chip8_keypad_ctrl_if;
  import chip8_keypad_ctrl_pkg::*;

  logic                 wait_req;
  logic                 wait_ack;
  logic [KEY_IDX_W-1:0] wait_key;

  modport master (output wait_req, input wait_ack, input wait_key);
  modport slave  (input wait_req, output wait_ack, output wait_key);

endinterface

// File: rtl/chip8_keypad_ctrl_debounce.sv
// rtl/chip8_keypad_ctrl_debounce.sv - single key synchroniser and tick-sampled debouncer
// Purpose: 2-flop sync of one raw key level, then flips key_state only after
//          STABLE_CNT consecutive tick samples disagree with it.
// Ports:   clk, reset_n (async, active-low), tick (sample strobe),
//          key_raw (async raw level), key_state (debounced level).
module chip8_keypad_ctrl_debounce #(
  parameter int STABLE_CNT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic key_raw,
  output logic key_state
);

  localparam int CNT_W = $clog2(STABLE_CNT + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CNT_W'(1);
    if (tick) begin
      if (sync2_q != state_q) begin
        // The STABLE_CNT-th disagreeing sample flips the state, so the
        // counter tops out at STABLE_CNT and can never wrap.
        if (cnt_inc == CNT_W'(STABLE_CNT)) begin
          state_d = ~state_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_state = state_q;

endmodule

// File: rtl/chip8_keypad_ctrl.sv
// rtl/chip8_keypad_ctrl.sv - CHIP-8 hex keypad conditioning and FX0A wait-for-key sequencer
// Purpose: debounces 16 raw keys, produces rising-edge press pulses and returns
//          one key index per FX0A request after that key is pressed and released.
// Ports:   clk, reset_n (async, active-low), keys_raw[15:0] (async raw levels),
//          key_state[15:0] (debounced), key_press[15:0] (1-cycle rise pulses),
//          wait_if (slave: wait_req in, wait_ack/wait_key out).
module chip8_keypad_ctrl
  import chip8_keypad_ctrl_pkg::*;
#(
  parameter int SAMPLE_DIV = 50000,
  parameter int STABLE_CNT = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] keys_raw,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  chip8_keypad_ctrl_if.slave  wait_if
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);

  logic [DIV_W-1:0]     div_q, div_d;
  logic                 tick;
  logic [NUM_KEYS-1:0]  key_state_w;
  logic [NUM_KEYS-1:0]  key_state_q, key_state_d;
  logic [NUM_KEYS-1:0]  key_press_q, key_press_d;
  wait_state_e          state_q, state_d;
  logic [KEY_IDX_W-1:0] sel_q, sel_d;
  logic [KEY_IDX_W-1:0] wait_key_q, wait_key_d;
  logic                 wait_ack_q, wait_ack_d;

  // Sample tick: one clk at the divider wrap.
  assign tick = (div_q == DIV_W'(SAMPLE_DIV - 1));

  always_comb begin
    div_d = tick ? '0 : div_q + DIV_W'(1);
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    chip8_keypad_ctrl_debounce #(
      .STABLE_CNT(STABLE_CNT)
    ) u_debounce (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick     (tick),
      .key_raw  (keys_raw[g]),
      .key_state(key_state_w[g])
    );
  end

  // Edge register: key_press appears the cycle after key_state rises.
  always_comb begin
    key_state_d = key_state_w;
    key_press_d = key_state_w & ~key_state_q;
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    wait_key_d = wait_key_q;
    wait_ack_d = 1'b0;
    case (state_q)
      // IDLE only looks at wait_req, so a press pulse in the same cycle the
      // request rises is not captured.
      ST_IDLE: begin
        if (wait_if.wait_req) state_d = ST_WAIT_PRESS;
      end
      // Keys already held at request time never pulse key_press again
      // until released and re-pressed, so they are naturally ignored.
      ST_WAIT_PRESS: begin
        if (!wait_if.wait_req) begin
          state_d = ST_IDLE;
        end else if (|key_press_q) begin
          sel_d   = lowest_set_idx(key_press_q);
          state_d = ST_WAIT_RELEASE;
        end
      end
      ST_WAIT_RELEASE: begin
        if (!wait_if.wait_req) begin
          state_d = ST_IDLE;
        end else if (!key_state_w[sel_q]) begin
          wait_ack_d = 1'b1;
          wait_key_d = sel_q;
          state_d    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!wait_if.wait_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q       <= '0;
      key_state_q <= '0;
      key_press_q <= '0;
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      wait_key_q  <= '0;
      wait_ack_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      key_state_q <= key_state_d;
      key_press_q <= key_press_d;
      state_q     <= state_d;
      sel_q       <= sel_d;
      wait_key_q  <= wait_key_d;
      wait_ack_q  <= wait_ack_d;
    end
  end

  assign key_state        = key_state_w;
  assign key_press        = key_press_q;
  assign wait_if.wait_ack = wait_ack_q;
  assign wait_if.wait_key = wait_key_q;

endmodule

// File: tb/tb_chip8_keypad_ctrl.sv
// tb/tb_chip8_keypad_ctrl.sv - directed self-checking bench for chip8_keypad_ctrl
module tb_chip8_keypad_ctrl;
  import chip8_keypad_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] keys_raw;
  logic [15:0] key_state;
  logic [15:0] key_press;

  int          checks = 0;
  int          errors = 0;
  int          ack_cnt = 0;
  logic [15:0] press_acc;
  logic [15:0] state_acc;

  chip8_keypad_ctrl_if wif ();

  chip8_keypad_ctrl #(
    .SAMPLE_DIV(4),
    .STABLE_CNT(3)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .keys_raw (keys_raw),
    .key_state(key_state),
    .key_press(key_press),
    .wait_if  (wif)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle, observed at the falling edge.
  task automatic step();
    @(negedge clk);
    if (wif.wait_ack === 1'b1) ack_cnt++;
    press_acc |= key_press;
    state_acc |= key_state;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_bit(input string tag, input int idx, input logic val, input int limit);
    int n;
    n = 0;
    while (key_state[idx] !== val && n < limit) begin
      step();
      n++;
    end
    check_eq({tag, "_in_time"}, 32'(key_state[idx] === val), 32'd1);
  endtask

  initial begin
    reset_n      = 1'b0;
    keys_raw     = 16'h0000;
    wif.wait_req = 1'b0;
    press_acc    = '0;
    state_acc    = '0;

    // 1. reset values
    run(3);
    check_eq("rst_key_state", 32'(key_state), 32'h0);
    check_eq("rst_key_press", 32'(key_press), 32'h0);
    check_eq("rst_wait_ack", 32'(wif.wait_ack), 32'h0);
    check_eq("rst_wait_key", 32'(wif.wait_key), 32'h0);
    reset_n = 1'b1;
    run(5);

    // 2. debounce of key 5
    keys_raw[5] = 1'b1;
    wait_bit("deb5_rise", 5, 1'b1, 18);
    check_eq("deb5_state", 32'(key_state), 32'h0020);
    check_eq("deb5_press_early", 32'(key_press), 32'h0);
    step();
    check_eq("deb5_press", 32'(key_press), 32'h0020);
    step();
    check_eq("deb5_press_one_clk", 32'(key_press), 32'h0);
    press_acc   = '0;
    keys_raw[5] = 1'b0;
    wait_bit("deb5_fall", 5, 1'b0, 18);
    run(3);
    check_eq("deb5_no_press_on_fall", 32'(press_acc), 32'h0);
    check_eq("deb5_state_low", 32'(key_state), 32'h0);

    // 3. glitch on key 3: 8 cycles high covers exactly 2 ticks
    press_acc   = '0;
    state_acc   = '0;
    keys_raw[3] = 1'b1;
    run(8);
    keys_raw[3] = 1'b0;
    run(30);
    check_eq("glitch_state", 32'(state_acc), 32'h0);
    check_eq("glitch_press", 32'(press_acc), 32'h0);

    // 4. FX0A with key 0xA
    wif.wait_req = 1'b1;
    run(2);
    check_eq("fx0a_wait_press", 32'(dut.state_q), 32'(ST_WAIT_PRESS));
    ack_cnt      = 0;
    keys_raw[10] = 1'b1;
    wait_bit("fx0a_rise", 10, 1'b1, 18);
    run(2);
    check_eq("fx0a_no_ack_while_held", 32'(ack_cnt), 32'd0);
    keys_raw[10] = 1'b0;
    run(25);
    check_eq("fx0a_ack_count", 32'(ack_cnt), 32'd1);
    check_eq("fx0a_wait_key", 32'(wif.wait_key), 32'hA);
    ack_cnt      = 0;
    keys_raw[10] = 1'b1;
    wait_bit("fx0a_rise2", 10, 1'b1, 18);
    keys_raw[10] = 1'b0;
    run(25);
    check_eq("fx0a_no_second_ack", 32'(ack_cnt), 32'd0);
    check_eq("fx0a_key_held", 32'(wif.wait_key), 32'hA);
    wif.wait_req = 1'b0;
    run(2);
    check_eq("fx0a_back_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // 5. priority: 7 and 2 on the same tick
    wif.wait_req = 1'b1;
    run(2);
    ack_cnt     = 0;
    keys_raw[7] = 1'b1;
    keys_raw[2] = 1'b1;
    wait_bit("prio_rise", 7, 1'b1, 18);
    check_eq("prio_both", 32'(key_state), 32'h0084);
    run(2);
    check_eq("prio_sel", 32'(dut.sel_q), 32'd2);
    keys_raw[7] = 1'b0;
    wait_bit("prio_fall7", 7, 1'b0, 18);
    run(3);
    check_eq("prio_no_ack_on_7", 32'(ack_cnt), 32'd0);
    keys_raw[2] = 1'b0;
    run(25);
    check_eq("prio_ack", 32'(ack_cnt), 32'd1);
    check_eq("prio_wait_key", 32'(wif.wait_key), 32'h2);

    // 6. held key ignored, abort in WAIT_RELEASE
    wif.wait_req = 1'b0;
    run(2);
    keys_raw[4] = 1'b1;
    wait_bit("held4_rise", 4, 1'b1, 18);
    run(3);
    wif.wait_req = 1'b1;
    ack_cnt      = 0;
    run(10);
    check_eq("held4_ignored", 32'(dut.state_q), 32'(ST_WAIT_PRESS));
    keys_raw[12] = 1'b1;
    wait_bit("abort_rise12", 12, 1'b1, 18);
    run(2);
    check_eq("abort_wait_release", 32'(dut.state_q), 32'(ST_WAIT_RELEASE));
    check_eq("abort_sel", 32'(dut.sel_q), 32'd12);
    wif.wait_req = 1'b0;
    run(2);
    check_eq("abort_idle", 32'(dut.state_q), 32'(ST_IDLE));
    keys_raw[12] = 1'b0;
    keys_raw[4]  = 1'b0;
    run(25);
    check_eq("abort_no_ack", 32'(ack_cnt), 32'd0);
    check_eq("abort_key_kept", 32'(wif.wait_key), 32'h2);

    // 7. asynchronous reset in mid-clock with state and wait_key non-zero
    keys_raw[9] = 1'b1;
    wait_bit("rst9_rise", 9, 1'b1, 18);
    check_eq("rst9_state", 32'(key_state), 32'h0200);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_key_state", 32'(key_state), 32'h0);
    check_eq("async_rst_key_press", 32'(key_press), 32'h0);
    check_eq("async_rst_wait_ack", 32'(wif.wait_ack), 32'h0);
    check_eq("async_rst_wait_key", 32'(wif.wait_key), 32'h0);
    check_eq("async_rst_fsm", 32'(dut.state_q), 32'(ST_IDLE));
    keys_raw = 16'h0000;
    @(negedge clk);
    reset_n = 1'b1;
    run(5);
    check_eq("post_rst_state", 32'(key_state), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
